// File: rtl/dac_spi_pkg.sv
// ---------------------------------------------------------------------------
// dac_spi_pkg
//  Shared constants and types for the AD9783-style SPI responder.
//  Frame layout (16 bits, MSB first):
//    [15]    R/W (1 = read)
//    [14:13] N (byte count, ignored; single-byte transfers only)
//    [12:8]  register address
//    [7:0]   data
//  The first 8 bits (R/W, N, address) form the header byte.
// ---------------------------------------------------------------------------
package dac_spi_pkg;

   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 8;
   localparam int FRAME_W  = 16;
   localparam int HDR_W    = 8;
   localparam int N_REGS   = 1 << ADDR_W;

   // Bit positions inside the 16-bit frame
   localparam int FRM_RW_BIT   = 15;
   localparam int FRM_N_MSB    = 14;
   localparam int FRM_N_LSB    = 13;
   localparam int FRM_ADDR_MSB = 12;
   localparam int FRM_ADDR_LSB = 8;

   // Same fields relative to the header byte
   localparam int HDR_RW_BIT   = FRM_RW_BIT   - DATA_W;
   localparam int HDR_ADDR_MSB = FRM_ADDR_MSB - DATA_W;
   localparam int HDR_ADDR_LSB = FRM_ADDR_LSB - DATA_W;

   // Register that becomes the abort counter when the counter build is used
   localparam logic [ADDR_W-1:0] ERRCNT_ADDR = 5'h1F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_RD,
      ST_WR,
      ST_DONE
   } spi_state_e;

   // Saturating increment, holds at all-ones
   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/spi_in_sync.sv
// ---------------------------------------------------------------------------
// spi_in_sync
//  N_SYNC-stage synchroniser for SCS, SCK and SDI followed by one
//  edge-detect register on SCS and SCK. SDI goes through the same depth so
//  its level lines up with the SCK rising-edge pulse.
//  Ports:
//    clk_in, rst_in     clock, async active-low reset
//    scs_i/sck_i/sdi_i  raw SPI pins
//    scs_rise_o/fall_o  one-cycle pulses on chip-select edges
//    sck_rise_o/fall_o  one-cycle pulses on serial-clock edges
//    sdi_o              synchronised SDI level
// ---------------------------------------------------------------------------
module spi_in_sync #(
   parameter int N_SYNC = 2
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic scs_i,
   input  logic sck_i,
   input  logic sdi_i,
   output logic scs_rise_o,
   output logic scs_fall_o,
   output logic sck_rise_o,
   output logic sck_fall_o,
   output logic sdi_o
);

   logic [N_SYNC-1:0] scs_sync_q, sck_sync_q, sdi_sync_q;
   logic              scs_prev_q, sck_prev_q;

   // SCS chain resets to its idle (high) level so reset release with the bus
   // idle does not look like a chip-select edge.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         scs_sync_q <= '1;
         sck_sync_q <= '0;
         sdi_sync_q <= '0;
         scs_prev_q <= 1'b1;
         sck_prev_q <= 1'b0;
      end else begin
         scs_sync_q <= {scs_sync_q[N_SYNC-2:0], scs_i};
         sck_sync_q <= {sck_sync_q[N_SYNC-2:0], sck_i};
         sdi_sync_q <= {sdi_sync_q[N_SYNC-2:0], sdi_i};
         scs_prev_q <= scs_sync_q[N_SYNC-1];
         sck_prev_q <= sck_sync_q[N_SYNC-1];
      end
   end

   assign scs_rise_o =  scs_sync_q[N_SYNC-1] & ~scs_prev_q;
   assign scs_fall_o = ~scs_sync_q[N_SYNC-1] &  scs_prev_q;
   assign sck_rise_o =  sck_sync_q[N_SYNC-1] & ~sck_prev_q;
   assign sck_fall_o = ~sck_sync_q[N_SYNC-1] &  sck_prev_q;
   assign sdi_o      =  sdi_sync_q[N_SYNC-1];

endmodule

// File: rtl/dac_spi_responder.sv
// ---------------------------------------------------------------------------
// dac_spi_responder
//  SPI target emulating the AD9783 serial port (16-bit frames, 32 x 8-bit
//  register file, SPI mode 0). SCS/SCK/SDI are oversampled in clk_in.
//  Ports:
//    clk_in, rst_in          clock (SCK <= clk_in/8), async active-low reset
//    spi_scs_in/sck_in/sdi_in SPI inputs from the master
//    spi_sdo_out, _oe_out    read data and its drive enable
//    wr_stb_out/addr/data    one-cycle report of each committed SPI write
//    smp_dly_out             live copy of register SMP_ADDR
//    reg_rd_addr_in/data_out local read port, registered, 1-cycle latency
//  Build option DAC_SPI_RESP_ERRCNT_EN: register 5'h1F becomes a read-only
//  saturating count of aborted frames; SPI writes to it are dropped.
// ---------------------------------------------------------------------------
module dac_spi_responder
   import dac_spi_pkg::*;
#(
   parameter int                N_SYNC   = 2,
   parameter logic [DATA_W-1:0] REG_RST  = 8'h00,
   parameter logic [ADDR_W-1:0] SMP_ADDR = 5'h05
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              spi_scs_in,
   input  logic              spi_sck_in,
   input  logic              spi_sdi_in,
   output logic              spi_sdo_out,
   output logic              spi_sdo_oe_out,
   output logic              wr_stb_out,
   output logic [ADDR_W-1:0] wr_addr_out,
   output logic [DATA_W-1:0] wr_data_out,
   output logic [DATA_W-1:0] smp_dly_out,
   input  logic [ADDR_W-1:0] reg_rd_addr_in,
   output logic [DATA_W-1:0] reg_rd_data_out
);

   logic scs_rise, scs_fall, sck_rise, sck_fall, sdi;

   spi_in_sync #(.N_SYNC(N_SYNC)) u_sync (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .scs_i      (spi_scs_in),
      .sck_i      (spi_sck_in),
      .sdi_i      (spi_sdi_in),
      .scs_rise_o (scs_rise),
      .scs_fall_o (scs_fall),
      .sck_rise_o (sck_rise),
      .sck_fall_o (sck_fall),
      .sdi_o      (sdi)
   );

   spi_state_e        state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   // Shift registers keep only the bits still needed; the incoming bit is
   // appended combinationally so the full byte exists on the 8th edge.
   logic [HDR_W-2:0]  hdr_q, hdr_d;
   logic [DATA_W-2:0] dat_q, dat_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              sdo_q, sdo_d;
   logic              oe_q, oe_d;
   logic              stb_q, stb_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              reg_we;
   logic [DATA_W-1:0] regs_q [N_REGS];
   logic [DATA_W-1:0] rd_q;

   logic [HDR_W-1:0]  hdr_full;
   logic [DATA_W-1:0] dat_full;
   logic [ADDR_W-1:0] hdr_addr;
   logic [DATA_W-1:0] spi_rd_val;
   logic [DATA_W-1:0] loc_rd_val;
   logic              wr_block;

   assign hdr_full = {hdr_q, sdi};
   assign dat_full = {dat_q, sdi};
   assign hdr_addr = hdr_full[HDR_ADDR_MSB:HDR_ADDR_LSB];

`ifdef DAC_SPI_RESP_ERRCNT_EN
   logic [DATA_W-1:0] err_cnt_q;
   logic              frame_abort;

   // Abort = chip select released while a frame is still incomplete
   assign frame_abort = scs_rise &&
                        (state_q == ST_HDR || state_q == ST_RD || state_q == ST_WR);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)          err_cnt_q <= '0;
      else if (frame_abort) err_cnt_q <= sat_inc(err_cnt_q);
   end

   assign spi_rd_val = (hdr_addr == ERRCNT_ADDR) ? err_cnt_q : regs_q[hdr_addr];
   assign loc_rd_val = (reg_rd_addr_in == ERRCNT_ADDR) ? err_cnt_q : regs_q[reg_rd_addr_in];
   assign wr_block   = (hdr_q[HDR_ADDR_MSB:HDR_ADDR_LSB] == ERRCNT_ADDR);
`else
   assign spi_rd_val = regs_q[hdr_addr];
   assign loc_rd_val = regs_q[reg_rd_addr_in];
   assign wr_block   = 1'b0;
`endif

   // Frame FSM: next state, shift registers and registered outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      dat_d   = dat_q;
      sh_d    = sh_q;
      sdo_d   = sdo_q;
      oe_d    = oe_q;
      stb_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      reg_we  = 1'b0;

      if (scs_fall) begin
         // Also covers a select glitch mid-frame: restart cleanly
         state_d = ST_HDR;
         cnt_d   = '0;
         sdo_d   = 1'b0;
         oe_d    = 1'b0;
      end else if (scs_rise) begin
         // Anything short of DONE is discarded without a write
         state_d = ST_IDLE;
         cnt_d   = '0;
         sdo_d   = 1'b0;
         oe_d    = 1'b0;
      end else begin
         unique case (state_q)
            ST_HDR: begin
               if (sck_rise) begin
                  hdr_d = hdr_full[HDR_W-2:0];
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     // Load read data now; MSB goes out on the next SCK fall
                     sh_d    = spi_rd_val;
                     state_d = hdr_full[HDR_RW_BIT] ? ST_RD : ST_WR;
                  end
               end
            end
            ST_RD: begin
               if (sck_fall) begin
                  sdo_d = sh_q[DATA_W-1];
                  sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                  oe_d  = 1'b1;
               end else if (sck_rise) begin
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_d = ST_DONE;
                     sdo_d   = 1'b0;
                     oe_d    = 1'b0;
                  end
               end
            end
            ST_WR: begin
               if (sck_rise) begin
                  dat_d = dat_full[DATA_W-2:0];
                  cnt_d = cnt_q + 3'd1;
                  if (cnt_q == 3'd7) begin
                     state_d = ST_DONE;
                     if (!wr_block) begin
                        reg_we  = 1'b1;
                        stb_d   = 1'b1;
                        waddr_d = hdr_q[HDR_ADDR_MSB:HDR_ADDR_LSB];
                        wdata_d = dat_full;
                     end
                  end
               end
            end
            default: ;   // IDLE waits for SCS fall, DONE ignores SCK
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hdr_q   <= '0;
         dat_q   <= '0;
         sh_q    <= '0;
         sdo_q   <= 1'b0;
         oe_q    <= 1'b0;
         stb_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         dat_q   <= dat_d;
         sh_q    <= sh_d;
         sdo_q   <= sdo_d;
         oe_q    <= oe_d;
         stb_q   <= stb_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   // Register file updates on the same edge that raises the strobe. The
   // local read samples the array on that edge too, so it returns old data.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < N_REGS; i++) regs_q[i] <= REG_RST;
         rd_q <= '0;
      end else begin
         if (reg_we) regs_q[waddr_d] <= wdata_d;
         rd_q <= loc_rd_val;
      end
   end

   assign spi_sdo_out     = sdo_q;
   assign spi_sdo_oe_out  = oe_q;
   assign wr_stb_out      = stb_q;
   assign wr_addr_out     = waddr_q;
   assign wr_data_out     = wdata_q;
   assign smp_dly_out     = regs_q[SMP_ADDR];
   assign reg_rd_data_out = rd_q;

endmodule
